wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
Shares the register file's single write port among three writeback requesters: EXU (index 0), LSU (index 1) and CSR (index 2). Each requester has a one-entry holding buffer with a valid/ready handshake. A round-robin arbiter drains the buffers into a registered write port. A scoreboard of pending destination registers drives RAW hazard flags back to decode, so that decode can stall until the producing write has landed.

Parameters:
XLEN, 64, data width of register writes
NSRC, 3, number of requesters (fixed at 3; index 0=EXU, 1=LSU, 2=CSR)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
exu_valid  in  1  EXU write request
exu_ready  out  1  EXU buffer can accept
exu_rd  in  5  EXU destination register
exu_data  in  XLEN  EXU write data
lsu_valid / lsu_ready / lsu_rd / lsu_data  in/out/in/in  1/1/5/XLEN  same meanings, LSU source
csr_valid / csr_ready / csr_rd / csr_data  in/out/in/in  1/1/5/XLEN  same meanings, CSR source
wb_en  out  1  register-file write enable
wb_addr  out  5  register-file write address
wb_data  out  XLEN  register-file write data
rs1_q  in  5  decode's rs1 address
rs2_q  in  5  decode's rs2 address
hazard_rs1  out  1  rs1_q has a pending write
hazard_rs2  out  1  rs2_q has a pending write
busy  out  1  at least one buffer occupied or wb_en high

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All buffers are emptied; pending writes are discarded.
  - wb_en=0, wb_addr=0, wb_data=0.
  - Round-robin pointer last_grant=2, so EXU has first priority after reset.
  - The ready outputs are forced to 0 while rst_n=0.
- Buffer i holds the state full_i, addr_i and data_i.
- Ready rule: ready_i = !full_i | grant_i. A granted buffer accepts a new request in the same cycle it drains.
- Accept on valid_i & ready_i at a clk edge:
  - rd != 0: full_i<=1 and the rd/data are latched.
  - rd == 0: the request is accepted and discarded; full_i is unchanged, except that if grant_i is also active the buffer clears.
- Arbitration is combinational over the full buffers.
  - Search order starts at (last_grant+1) mod 3.
  - At most one grant per cycle.
  - On a grant: full_i<=0 unless refilled, last_grant<=i, wb_en<=1, wb_addr<=addr_i, wb_data<=data_i.
  - With no grant: wb_en<=0, and wb_addr/wb_data hold their previous values.
- Latency: a request accepted at edge t, when uncontended, produces wb_en=1 in the cycle following edge t+1. Fairness bound: at most 2 other grants occur before a full buffer is granted.
- Throughput: 1 write per cycle sustained; each source alone can sustain 1 per cycle via the grant-refill path.
- Hazard rule: hazard_rsK=1 iff rsK_q != 0 and either:
  - rsK_q equals addr_i of some full buffer i, or
  - wb_en=1 and wb_addr == rsK_q.
  - Hazard outputs are purely combinational from current state. A request presented in the same cycle is not yet visible.
- WAW: two pending writes to the same rd retire in arbitration order, not program order. Decode must not issue a second writer to an rd while hazard is set for that rd.
- busy = full_0 | full_1 | full_2 | wb_en.
- Reset mid-operation: buffered writes are lost. The wb_en in flight on the reset edge is cleared, and nothing is written after reset.

Optional Feature:
WB_FIXED_PRIO_EN:
- Defined: fixed priority EXU > LSU > CSR. last_grant is not used, and a continuously full EXU buffer can starve LSU and CSR.
- Undefined (default): round-robin as described under Behaviour.

Test Plan:
- Reset, then EXU only: exu_valid=1, rd=5, data=0x1234 for 1 cycle -> exu_ready=1; wb_en=1, wb_addr=5, wb_data=0x1234 exactly 2 edges after acceptance; busy returns to 0 afterwards.
- All three sources valid in the same cycle (rd 1/2/3, data 0xA/0xB/0xC) after reset -> wb sequence EXU(1,0xA), LSU(2,0xB), CSR(3,0xC) on consecutive cycles. With WB_FIXED_PRIO_EN and EXU re-presenting rd=1 every cycle -> LSU is never granted while EXU is full.
- Back-to-back LSU stream rd=8..15, valid held high -> lsu_ready stays 1; 8 consecutive wb_en pulses with wb_addr 8..15 in order.
- Write to x0: csr_valid=1, rd=0, data=0xFFFF -> csr_ready=1, wb_en never asserts, busy stays 0.
- Hazard: LSU buffer holds rd=7, rs1_q=7, rs2_q=0 -> hazard_rs1=1, hazard_rs2=0. hazard_rs1 stays 1 through the wb_en cycle with wb_addr=7 and drops to 0 the cycle after.
- Reset with all buffers full -> after rst_n deasserts, wb_en=0, busy=0 and no write occurs.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register file's single write port among three
// writeback requesters (0=EXU, 1=LSU, 2=CSR). Each requester owns a one-entry
// holding buffer with a valid/ready handshake. An arbiter drains the full
// buffers into a registered write port. A scoreboard built from the buffer
// contents and the in-flight write raises RAW hazard flags for decode.
//
// Optional feature (compile-time macro WB_FIXED_PRIO_EN):
//   defined   - fixed priority EXU > LSU > CSR; a continuously full EXU buffer
//               can starve LSU and CSR.
//   undefined - round-robin starting after the last granted source (default).
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   {exu,lsu,csr}_valid/_ready  per-source handshake
//   {exu,lsu,csr}_rd/_data      per-source destination register and data
//   wb_en, wb_addr, wb_data     registered register-file write port
//   rs1_q, rs2_q                decode's source register addresses
//   hazard_rs1, hazard_rs2      source register has a pending write
//   busy                        any buffer occupied or a write in flight

// One-entry holding buffer for a single requester.
module wb_port_arbiter_buf #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] data,
    input  logic            grant,
    output logic            ready,
    output logic            full,
    output logic [4:0]      addr,
    output logic [XLEN-1:0] buf_data
);
    logic acc;

    // A granted buffer drains this cycle, so it can take a refill at once.
    assign ready = rst_n & (~full | grant);
    assign acc   = valid & ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full     <= 1'b0;
            addr     <= '0;
            buf_data <= '0;
        end else begin
            // Grant clears first; a non-x0 accept in the same cycle refills.
            // Writes to x0 are swallowed without occupying the buffer.
            if (grant)
                full <= 1'b0;
            if (acc && rd != 5'd0) begin
                full     <= 1'b1;
                addr     <= rd;
                buf_data <= data;
            end
        end
    end
endmodule

module wb_port_arbiter #(
    parameter int XLEN = 64,
    parameter int NSRC = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exu_valid,
    output logic            exu_ready,
    input  logic [4:0]      exu_rd,
    input  logic [XLEN-1:0] exu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            csr_valid,
    output logic            csr_ready,
    input  logic [4:0]      csr_rd,
    input  logic [XLEN-1:0] csr_data,
    output logic            wb_en,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    input  logic [4:0]      rs1_q,
    input  logic [4:0]      rs2_q,
    output logic            hazard_rs1,
    output logic            hazard_rs2,
    output logic            busy
);
    localparam int IW = 2;

    logic [NSRC-1:0]           in_valid;
    logic [NSRC-1:0][4:0]      in_rd;
    logic [NSRC-1:0][XLEN-1:0] in_data;
    logic [NSRC-1:0]           ready;
    logic [NSRC-1:0]           full;
    logic [NSRC-1:0][4:0]      addr;
    logic [NSRC-1:0][XLEN-1:0] data;
    logic [NSRC-1:0]           grant;
    logic [IW-1:0]             gidx;

    assign in_valid = {csr_valid, lsu_valid, exu_valid};
    assign in_rd    = {csr_rd, lsu_rd, exu_rd};
    assign in_data  = {csr_data, lsu_data, exu_data};

    assign exu_ready = ready[0];
    assign lsu_ready = ready[1];
    assign csr_ready = ready[2];

    for (genvar i = 0; i < NSRC; i++) begin : g_buf
        wb_port_arbiter_buf #(.XLEN(XLEN)) u_buf (
            .clk      (clk),
            .rst_n    (rst_n),
            .valid    (in_valid[i]),
            .rd       (in_rd[i]),
            .data     (in_data[i]),
            .grant    (grant[i]),
            .ready    (ready[i]),
            .full     (full[i]),
            .addr     (addr[i]),
            .buf_data (data[i])
        );
    end

`ifdef WB_FIXED_PRIO_EN
    // Lowest index wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (full[k] && grant == '0) begin
                grant[k] = 1'b1;
                gidx     = IW'(k);
            end
        end
    end
`else
    logic [IW-1:0] last_grant;
    logic [IW-1:0] idx;

    // Search starts just after the previous winner, so any full buffer sees
    // at most NSRC-1 other grants before its own.
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        for (int k = 1; k <= NSRC; k++) begin
            idx = IW'((int'(last_grant) + k) % NSRC);
            if (full[idx] && grant == '0) begin
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_grant <= IW'(NSRC - 1);
        else if (grant != '0)
            last_grant <= gidx;
    end
`endif

    // Registered write port; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else if (grant != '0) begin
            wb_en   <= 1'b1;
            wb_addr <= addr[gidx];
            wb_data <= data[gidx];
        end else begin
            wb_en   <= 1'b0;
        end
    end

    // A register is pending while it sits in a full buffer or is being
    // written this cycle; x0 is never hazardous.
    always_comb begin
        hazard_rs1 = 1'b0;
        hazard_rs2 = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (full[i] && addr[i] == rs1_q) hazard_rs1 = 1'b1;
            if (full[i] && addr[i] == rs2_q) hazard_rs2 = 1'b1;
        end
        if (wb_en && wb_addr == rs1_q) hazard_rs1 = 1'b1;
        if (wb_en && wb_addr == rs2_q) hazard_rs2 = 1'b1;
        if (rs1_q == 5'd0) hazard_rs1 = 1'b0;
        if (rs2_q == 5'd0) hazard_rs2 = 1'b0;
    end

    assign busy = (|full) | wb_en;
endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            exu_valid, lsu_valid, csr_valid;
    logic            exu_ready, lsu_ready, csr_ready;
    logic [4:0]      exu_rd, lsu_rd, csr_rd;
    logic [XLEN-1:0] exu_data, lsu_data, csr_data;
    logic            wb_en;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic [4:0]      rs1_q, rs2_q;
    logic            hazard_rs1, hazard_rs2;
    logic            busy;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.XLEN(XLEN), .NSRC(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .csr_valid(csr_valid), .csr_ready(csr_ready), .csr_rd(csr_rd), .csr_data(csr_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rs1_q(rs1_q), .rs2_q(rs2_q),
        .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exu_valid = 0; lsu_valid = 0; csr_valid = 0;
        exu_rd = 0; lsu_rd = 0; csr_rd = 0;
        exu_data = 0; lsu_data = 0; csr_data = 0;
        rs1_q = 0; rs2_q = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 0;
        step();
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        step();
        step();
        checks++;
        if ({wb_en, wb_addr, wb_data} !== {1'b0, 5'd0, 64'd0}) begin
            errors++;
            $display("FAIL reset_wb: got en=%0b addr=%0d data=%0h exp 0/0/0", wb_en, wb_addr, wb_data);
        end
        checks++;
        if ({exu_ready, lsu_ready, csr_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready: got %b exp 000", {exu_ready, lsu_ready, csr_ready});
        end
        checks++;
        if ({busy, hazard_rs1, hazard_rs2} !== 3'b000) begin
            errors++;
            $display("FAIL reset_busy_haz: got %b exp 000", {busy, hazard_rs1, hazard_rs2});
        end
        rst_n = 1;
        #1;
        checks++;
        if ({exu_ready, lsu_ready, csr_ready} !== 3'b111) begin
            errors++;
            $display("FAIL post_reset_ready: got %b exp 111", {exu_ready, lsu_ready, csr_ready});
        end
    endtask

    task automatic test_exu_single();
        apply_reset();
        exu_valid = 1; exu_rd = 5; exu_data = 64'h1234;
        #1;
        checks++;
        if (exu_ready !== 1'b1) begin
            errors++;
            $display("FAIL exu_ready: got %b exp 1", exu_ready);
        end
        step();
        exu_valid = 0;
        checks++;
        if ({wb_en, busy} !== 2'b01) begin
            errors++;
            $display("FAIL exu_t1: got en=%b busy=%b exp en=0 busy=1", wb_en, busy);
        end
        step();
        checks++;
        if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd5, 64'h1234}) begin
            errors++;
            $display("FAIL exu_wb: got en=%b addr=%0d data=%0h exp 1/5/1234", wb_en, wb_addr, wb_data);
        end
        step();
        checks++;
        if ({wb_en, busy, wb_data} !== {1'b0, 1'b0, 64'h1234}) begin
            errors++;
            $display("FAIL exu_idle: got en=%b busy=%b data=%0h exp 0/0/1234", wb_en, busy, wb_data);
        end
    endtask

    task automatic test_all_three();
        logic [4:0]      exp_a [3];
        logic [XLEN-1:0] exp_d [3];
        exp_a = '{5'd1, 5'd2, 5'd3};
        exp_d = '{64'hA, 64'hB, 64'hC};
        apply_reset();
        exu_valid = 1; exu_rd = 1; exu_data = 64'hA;
        lsu_valid = 1; lsu_rd = 2; lsu_data = 64'hB;
        csr_valid = 1; csr_rd = 3; csr_data = 64'hC;
        #1;
        checks++;
        if ({exu_ready, lsu_ready, csr_ready} !== 3'b111) begin
            errors++;
            $display("FAIL all_ready: got %b exp 111", {exu_ready, lsu_ready, csr_ready});
        end
        step();
        clear_inputs();
        checks++;
        if ({wb_en, busy} !== 2'b01) begin
            errors++;
            $display("FAIL all_t1: got en=%b busy=%b exp 0/1", wb_en, busy);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({wb_en, wb_addr, wb_data} !== {1'b1, exp_a[i], exp_d[i]}) begin
                errors++;
                $display("FAIL all_seq%0d: got en=%b addr=%0d data=%0h exp 1/%0d/%0h",
                         i, wb_en, wb_addr, wb_data, exp_a[i], exp_d[i]);
            end
        end
        step();
        checks++;
        if ({wb_en, busy} !== 2'b00) begin
            errors++;
            $display("FAIL all_idle: got en=%b busy=%b exp 0/0", wb_en, busy);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        lsu_valid = 1;
        for (int i = 0; i < 8; i++) begin
            lsu_rd = 5'(8 + i); lsu_data = 64'(100 + i);
            #1;
            checks++;
            if (lsu_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d: got %b exp 1", i, lsu_ready);
            end
            step();
            if (i >= 1) begin
                checks++;
                if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'(7 + i), 64'(99 + i)}) begin
                    errors++;
                    $display("FAIL b2b_wb%0d: got en=%b addr=%0d data=%0d exp 1/%0d/%0d",
                             i, wb_en, wb_addr, wb_data, 7 + i, 99 + i);
                end
            end
        end
        lsu_valid = 0;
        step();
        checks++;
        if ({wb_en, wb_addr, wb_data} !== {1'b1, 5'd15, 64'd107}) begin
            errors++;
            $display("FAIL b2b_last: got en=%b addr=%0d data=%0d exp 1/15/107", wb_en, wb_addr, wb_data);
        end
        step();
        checks++;
        if ({wb_en, busy} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle: got en=%b busy=%b exp 0/0", wb_en, busy);
        end
    endtask

    task automatic test_x0();
        apply_reset();
        csr_valid = 1; csr_rd = 0; csr_data = 64'hFFFF;
        #1;
        checks++;
        if (csr_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: got %b exp 1", csr_ready);
        end
        step();
        csr_valid = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({wb_en, busy} !== 2'b00) begin
                errors++;
                $display("FAIL x0_quiet%0d: got en=%b busy=%b exp 0/0", i, wb_en, busy);
            end
            step();
        end
    endtask

    task automatic test_hazard();
        apply_reset();
        lsu_valid = 1; lsu_rd = 7; lsu_data = 64'h77;
        rs1_q = 7; rs2_q = 0;
        #1;
        checks++;
        if (hazard_rs1 !== 1'b0) begin
            errors++;
            $display("FAIL haz_same_cycle: got %b exp 0", hazard_rs1);
        end
        step();
        lsu_valid = 0;
        #1;
        checks++;
        if ({hazard_rs1, hazard_rs2} !== 2'b10) begin
            errors++;
            $display("FAIL haz_buf: got %b exp 10", {hazard_rs1, hazard_rs2});
        end
        rs2_q = 6;
        #1;
        checks++;
        if (hazard_rs2 !== 1'b0) begin
            errors++;
            $display("FAIL haz_rs2_other: got %b exp 0", hazard_rs2);
        end
        step();
        checks++;
        if ({wb_en, wb_addr, hazard_rs1} !== {1'b1, 5'd7, 1'b1}) begin
            errors++;
            $display("FAIL haz_wb: got en=%b addr=%0d haz=%b exp 1/7/1", wb_en, wb_addr, hazard_rs1);
        end
        step();
        checks++;
        if ({wb_en, hazard_rs1} !== 2'b00) begin
            errors++;
            $display("FAIL haz_clear: got en=%b haz=%b exp 0/0", wb_en, hazard_rs1);
        end
        rs1_q = 0; rs2_q = 0;
    endtask

    task automatic test_reset_full();
        apply_reset();
        exu_valid = 1; exu_rd = 4; exu_data = 64'h4;
        lsu_valid = 1; lsu_rd = 5; lsu_data = 64'h5;
        csr_valid = 1; csr_rd = 6; csr_data = 64'h6;
        step();
        clear_inputs();
        step();
        checks++;
        if ({wb_en, wb_addr, busy} !== {1'b1, 5'd4, 1'b1}) begin
            errors++;
            $display("FAIL rf_pre: got en=%b addr=%0d busy=%b exp 1/4/1", wb_en, wb_addr, busy);
        end
        rst_n = 0;
        step();
        checks++;
        if ({wb_en, busy, exu_ready} !== 3'b000) begin
            errors++;
            $display("FAIL rf_in_reset: got en=%b busy=%b rdy=%b exp 0/0/0", wb_en, busy, exu_ready);
        end
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({wb_en, busy} !== 2'b00) begin
                errors++;
                $display("FAIL rf_after%0d: got en=%b busy=%b exp 0/0", i, wb_en, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exu_single();
        test_all_three();
        test_back_to_back();
        test_x0();
        test_hazard();
        test_reset_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
